rv_lsu: RTL and testbench
=========================

// Module: rv_lsu
// PURPOSE
//  Parametrised load/store unit between the RV datapath (ALU address, rs2 data, fun3) and a word-addressed data memory.
//  Performs B/H/W(/D) lane steering, byte-enable generation, sign/zero extension and legality checks from the byte address.
//  Sequenced by an FSM with a valid/ready request port and a variable-latency memory handshake with timeout.
// PARAMETERS
//  XLEN         32  data width; 32 or 64 (64 enables LD/SD/LWU)
//  AW           7   memory word-address width
//  MEM_TIMEOUT  16  max WAIT cycles before a load aborts with error; >=1
// PORTS
//  clk         in   1             clock, all state on rising edge
//  rst         in   1             reset, asynchronous, active-low
//  req_valid   in   1             request valid
//  req_ready   out  1             unit can accept a request
//  req_we      in   1             1=store, 0=load
//  req_fun3    in   3             RISC-V funct3 (size/sign)
//  req_addr    in   XLEN          byte address
//  req_wdata   in   XLEN          store data, LSB-aligned
//  req_rd      in   5             destination tag, echoed on response
//  resp_valid  out  1             one-cycle completion pulse
//  resp_data   out  XLEN          extended load data (0 for stores/errors)
//  resp_rd     out  5             echoed tag
//  resp_err    out  1             illegal fun3, misalignment or timeout
//  mem_req     out  1             memory request, held until mem_ready
//  mem_we      out  1             memory write
//  mem_addr    out  AW            word address = req_addr[AW+OFF-1:OFF], OFF=log2(XLEN/8)
//  mem_wdata   out  XLEN          store data shifted into byte lane
//  mem_wmask   out  XLEN/8        byte enables
//  mem_ready   in   1             memory accepts request this cycle
//  mem_rdata   in   XLEN          read data
//  mem_rvalid  in   1             read data valid
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; all other outputs 0; timeout counter 0. Reset mid-transaction abandons it; no response.
//  IDLE: req_ready=1. On req_valid&req_ready capture all req_* fields; illegal/misaligned -> ERR, else -> ISSUE.
//  ISSUE: mem_req=1, mem_* stable until mem_ready. On mem_ready: store -> DONE; load -> WAIT (counter cleared).
//  WAIT: counter increments each cycle; mem_rvalid -> register extended data, -> DONE; counter==MEM_TIMEOUT -> ERR.
//  DONE: resp_valid=1 one cycle, resp_err=0 -> IDLE. ERR: resp_valid=1, resp_err=1, resp_data=0 -> IDLE.
//  mem_rvalid outside WAIT is ignored (stale data after reset/timeout). mem_rvalid in the mem_ready cycle is ignored.
//  Latency: store accept->resp_valid = 2 + stall cycles; load = 3 + stall + memory latency. req_ready=0 outside IDLE.
//  Legal fun3: load 000 LB,001 LH,010 LW,100 LBU,101 LHU; XLEN=64 adds 011 LD,110 LWU. Store 000/001/010 (+011 at 64).
//  Lanes: off=req_addr[OFF-1:0]; mem_wmask=size mask<<off; mem_wdata=req_wdata<<(8*off); load = mem_rdata>>(8*off), then
//   sign-extend (LB/LH/LW@64) or zero-extend (LBU/LHU/LWU) to XLEN.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: off not a multiple of access size -> ERR, mem_req never asserted.
//  Not defined: off rounded down to size alignment, access proceeds, no error.
// STRUCTURE
//  lsu_pkg: fun3 localparams, state enum (IDLE,ISSUE,WAIT,DONE,ERR), size decode function, log2 offset constant.
//  Sub-module lsu_align (combinational): store shift/mask and load extract/extend; FSM and counter in rv_lsu.
// TESTING (XLEN=32, AW=7)
//  SW addr 0x10 data 0xDEADBEEF, mem_ready same cycle -> mem_addr 4, mask 1111, wdata 0xDEADBEEF; resp_valid 2 cycles after accept, err 0.
//  SB addr 0x13 data 0x000000A5 -> mem_addr 4, mask 1000, wdata[31:24]=0xA5; resp_data 0.
//  mem_rdata 0x80FF7F01: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LB 0x10 -> 0x00000001.
//  LW addr 0x12: with LSU_MISALIGN_TRAP_EN -> resp_err=1, mem_req stays 0; without -> mem_addr 4, full word returned.
//  MEM_TIMEOUT=8, load accepted, mem_rvalid never -> resp_err=1 after 8 WAIT cycles; later mem_rvalid ignored; req_ready=1.
//  rst low during WAIT -> outputs 0 immediately; after release req_ready=1, stale mem_rvalid gives no resp_valid; load fun3 011 -> err.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM states and decode helpers shared by rv_lsu and lsu_align.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    // Number of byte-offset bits inside one memory word.
    function automatic int off_bits(input int xlen);
        return xlen == 64 ? 3 : 2;
    endfunction

    // log2 of the access size in bytes.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    function automatic logic legal_fun3(input logic we, input logic [2:0] f3, input logic wide);
        return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W || (wide && f3 == F3_D))
                  : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU ||
                     (wide && (f3 == F3_D || f3 == F3_WU)));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module lsu_align import lsu_pkg::*; #(
    parameter int XLEN = 32,
    parameter int OFF  = 2
) (
    input  logic [2:0]        fun3,
    input  logic [OFF-1:0]    off,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   wlane,
    output logic [XLEN/8-1:0] wmask,
    output logic [XLEN-1:0]   rext
);

    logic [1:0]      size;
    logic [OFF-1:0]  eoff;
    logic [XLEN-1:0] rsh;
    logic [XLEN-1:0] vmask;

    // Offsets are rounded down to the access size, so a misaligned access never spills into the next word.
    always_comb begin
        size  = size_of(fun3);
        eoff  = off & ~OFF'((1 << size) - 1);
        wmask = ~({(XLEN/8){1'b1}} << (1 << size)) << eoff;
        wlane = wdata << {eoff, 3'b000};
        rsh   = rdata >> {eoff, 3'b000};
        vmask = ~({XLEN{1'b1}} << (8 << size));
        rext  = (rsh & vmask) | ((!fun3[2] && |(rsh & vmask & ~(vmask >> 1))) ? ~vmask : '0);
    end

endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit with lane steering, extension and a timed variable-latency memory handshake.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned accesses into errors instead of rounding the offset down.
module rv_lsu import lsu_pkg::*; #(
    parameter int XLEN        = 32,
    parameter int AW          = 7,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_fun3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid
);

    localparam int OFF = off_bits(XLEN);
    localparam int CW  = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [AW-1:0]     wa_q;
    logic [OFF-1:0]    off_q;
    logic [XLEN-1:0]   wdata_q, data_q, wlane, rext;
    logic [XLEN/8-1:0] wmask;
    logic [4:0]        rd_q;
    logic              bad;

    lsu_align #(.XLEN(XLEN), .OFF(OFF)) u_align (
        .fun3(f3_q), .off(off_q), .wdata(wdata_q), .rdata(mem_rdata),
        .wlane(wlane), .wmask(wmask), .rext(rext)
    );

    always_comb begin
        bad = !legal_fun3(req_we, req_fun3, XLEN == 64);
`ifdef LSU_MISALIGN_TRAP_EN
        bad = bad || ((req_addr[OFF-1:0] & OFF'((1 << size_of(req_fun3)) - 1)) != '0);
`endif
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    // rvalid wins over the timeout, so data on the last permitted WAIT cycle still completes.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? (bad ? ERR : ISSUE) : IDLE;
            ISSUE:   state_nx = mem_ready ? (we_q ? DONE : WAIT) : ISSUE;
            WAIT:    state_nx = mem_rvalid ? DONE : (cnt == CW'(MEM_TIMEOUT - 1) ? ERR : WAIT);
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            wa_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_fun3;
                wa_q    <= req_addr[AW+OFF-1:OFF];
                off_q   <= req_addr[OFF-1:0];
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
            end
            cnt <= state == WAIT ? cnt + 1'b1 : '0;
            if (state == WAIT && mem_rvalid) data_q <= rext;
        end

    always_comb begin
        req_ready  = state == IDLE;
        mem_req    = state == ISSUE;
        mem_we     = mem_req && we_q;
        mem_addr   = mem_req ? wa_q : '0;
        mem_wdata  = mem_we ? wlane : '0;
        mem_wmask  = mem_req ? wmask : '0;
        resp_valid = state == DONE || state == ERR;
        resp_err   = state == ERR;
        resp_data  = (state == DONE && !we_q) ? data_q : '0;
        resp_rd    = resp_valid ? rd_q : '0;
    end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed vector table, hand-written corner sequences and randomized loads/stores for rv_lsu.
module tb_rv_lsu;

    localparam int TO = 8;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_fun3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_data, mem_wdata;
    logic [4:0]  resp_rd;
    logic [6:0]  mem_addr;
    logic [3:0]  mem_wmask;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    rv_lsu #(.XLEN(32), .AW(7), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_fun3(req_fun3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic saw; logic [6:0] ma; logic [3:0] mm; logic [31:0] mw; logic mwe;
        logic rv; logic err; logic [31:0] data; logic [4:0] rd; int cyc;
    } obs_t;

    typedef struct {
        logic we; logic [2:0] f3; logic [31:0] addr, wdata, rdata;
        logic issue, err; logic [6:0] ma; logic [3:0] mm; logic [31:0] mw, data; int cyc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: byte-wise gather with arithmetic sign extension, latency from the handshake rules.
    function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr, wdata, rdata,
                                   input int stall, input int lat);
        vec_t e;
        int n, off, eo;
        logic legal;
        longint v;
        n = 1 << f3[1:0];
        off = int'(addr % 4);
        eo = off - off % n;
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        e.we = we; e.f3 = f3; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        e.issue = legal && !(TRAP && off % n != 0);
        e.err = !e.issue;
        e.ma = 7'(addr / 4);
        e.mm = '0;
        for (int b = 0; b < 4; b++) if (b >= eo && b < eo + n) e.mm[b] = 1'b1;
        e.mw = wdata << (8 * eo);
        v = 0;
        for (int i = 0; i < n && eo + i < 4; i++) v += longint'(rdata[8*(eo+i) +: 8]) << (8 * i);
        if (f3[2] == 1'b0 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        e.data = 32'(v);
        if (e.err)                       e.cyc = 1;
        else if (we)                     e.cyc = 2 + stall;
        else if (lat < 0 || lat >= TO)   e.cyc = 2 + stall + TO;
        else                             e.cyc = 3 + stall + lat;
        if (e.issue && !we && (lat < 0 || lat >= TO)) e.err = 1'b1;
        if (e.err || we) e.data = '0;
        return e;
    endfunction

    // One request; the memory stalls `stall` cycles, then returns data after `lat` WAIT cycles (lat<0: never).
    // With noise, rvalid is also driven with wrong data while the request is still outstanding.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, wdata, rdata,
                       input logic [4:0] rd, input int stall, input int lat, input bit noise, output obs_t o);
        int cnt;
        bit waiting;
        cnt = 0;
        waiting = 0;
        o = '{default: '0};
        req_valid = 1'b1; req_we = we; req_fun3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
        o.cyc = 1;
        while (o.cyc < 60) begin
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = ~rdata;
            if (resp_valid) begin
                o.rv = 1'b1; o.err = resp_err; o.data = resp_data; o.rd = resp_rd;
                break;
            end
            if (mem_req) begin
                o.saw = 1'b1; o.ma = mem_addr; o.mm = mem_wmask; o.mw = mem_wdata; o.mwe = mem_we;
                mem_rvalid = noise;
                if (cnt == stall) begin mem_ready = 1'b1; waiting = 1; cnt = 0; end
                else cnt++;
            end else if (waiting) begin
                if (cnt == lat) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
                cnt++;
            end
            @(negedge clk);
            o.cyc++;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic compare(input string tag, input vec_t e, input logic [4:0] rd, input obs_t o);
        chk({tag, " resp_valid"}, o.rv, 1'b1);
        chk({tag, " resp_err"}, o.err, e.err);
        chk({tag, " resp_data"}, o.data, e.data);
        chk({tag, " resp_rd"}, o.rd, rd);
        chk({tag, " latency"}, o.cyc, e.cyc);
        chk({tag, " mem_req seen"}, o.saw, e.issue);
        if (e.issue) begin
            chk({tag, " mem_addr"}, o.ma, e.ma);
            chk({tag, " mem_we"}, o.mwe, e.we);
            if (e.we) begin
                chk({tag, " mem_wmask"}, o.mm, e.mm);
                chk({tag, " mem_wdata"}, o.mw, e.mw);
            end
        end
    endtask

    vec_t tv[12];

    initial begin
        obs_t o;
        vec_t e;
        logic [31:0] rd32 = 32'h80FF7F01;
        //         we    f3    addr    wdata         rdata  issue  err  ma  mm     mw             data           cyc
        tv[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, '0,    1'b1, 1'b0, 4, 4'hF, 32'hDEADBEEF, 32'h0,         2};
        tv[1]  = '{1'b1, 3'd0, 32'h13, 32'h000000A5, '0,    1'b1, 1'b0, 4, 4'h8, 32'hA5000000, 32'h0,         2};
        tv[2]  = '{1'b0, 3'd0, 32'h13, '0,           rd32,  1'b1, 1'b0, 4, 4'h0, 32'h0,        32'hFFFFFF80,  3};
        tv[3]  = '{1'b0, 3'd4, 32'h13, '0,           rd32,  1'b1, 1'b0, 4, 4'h0, 32'h0,        32'h00000080,  3};
        tv[4]  = '{1'b0, 3'd1, 32'h12, '0,           rd32,  1'b1, 1'b0, 4, 4'h0, 32'h0,        32'hFFFF80FF,  3};
        tv[5]  = '{1'b0, 3'd0, 32'h10, '0,           rd32,  1'b1, 1'b0, 4, 4'h0, 32'h0,        32'h00000001,  3};
        tv[6]  = '{1'b0, 3'd2, 32'h12, '0,           rd32,  !TRAP, TRAP, 4, 4'h0, 32'h0,       TRAP ? 32'h0 : rd32, TRAP ? 1 : 3};
        tv[7]  = '{1'b1, 3'd1, 32'h11, 32'h00001234, '0,    !TRAP, TRAP, 4, 4'h3, 32'h00001234, 32'h0,       TRAP ? 1 : 2};
        tv[8]  = '{1'b1, 3'd4, 32'h20, 32'h11111111, '0,    1'b0, 1'b1, 8, 4'h0, 32'h0,        32'h0,         1};
        tv[9]  = '{1'b0, 3'd3, 32'h20, '0,           rd32,  1'b0, 1'b1, 8, 4'h0, 32'h0,        32'h0,         1};
        tv[10] = '{1'b0, 3'd5, 32'h12, '0,           rd32,  1'b1, 1'b0, 4, 4'h0, 32'h0,        32'h000080FF,  3};
        tv[11] = '{1'b1, 3'd1, 32'h12, 32'h0000BEEF, '0,    1'b1, 1'b0, 4, 4'hC, 32'hBEEF0000, 32'h0,         2};

        // Reset state
        #1;
        chk("reset req_ready", req_ready, 1'b1);
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset resp_valid", resp_valid, 1'b0);
        chk("reset outputs", {mem_addr, mem_wdata, mem_wmask, resp_data, resp_rd, resp_err, mem_we}, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            txn(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, tv[i].rdata, 5'(i + 1), 0, 0, 1'b0, o);
            compare($sformatf("vec%0d", i), tv[i], 5'(i + 1), o);
        end

        // Timeout: no rvalid ever, then late rvalid must be ignored
        txn(1'b0, 3'd2, 32'h20, '0, 32'h12345678, 5'd9, 0, -1, 1'b0, o);
        chk("timeout err", o.err, 1'b1);
        chk("timeout latency", o.cyc, 2 + TO);
        chk("timeout data", o.data, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
            @(negedge clk);
            chk("late rvalid resp_valid", resp_valid, 1'b0);
            chk("late rvalid req_ready", req_ready, 1'b1);
        end
        mem_rvalid = 1'b0;

        // rvalid on the last permitted WAIT cycle still completes
        e = model(1'b0, 3'd2, 32'h24, '0, 32'h0BADBEEF, 0, TO - 1);
        txn(1'b0, 3'd2, 32'h24, '0, 32'h0BADBEEF, 5'd3, 0, TO - 1, 1'b0, o);
        compare("last wait cycle", e, 5'd3, o);

        // Reset asserted during WAIT
        req_valid = 1'b1; req_we = 1'b0; req_fun3 = 3'd2; req_addr = 32'h30; req_rd = 5'd7;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst in WAIT req_ready", req_ready, 1'b1);
        chk("rst in WAIT quiet", {mem_req, resp_valid, resp_err, resp_data, resp_rd, mem_addr}, '0);
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale rvalid resp_valid", resp_valid, 1'b0);
        end
        mem_rvalid = 1'b0;
        e = model(1'b0, 3'd3, 32'h40, '0, '0, 0, 0);
        txn(1'b0, 3'd3, 32'h40, '0, '0, 5'd11, 0, 0, 1'b0, o);
        compare("LD fun3 after reset", e, 5'd11, o);

        // Randomized traffic against the model
        for (int k = 0; k < 200; k++) begin
            logic we;
            logic [2:0] f3;
            logic [31:0] addr, wdata, rdata;
            logic [4:0] rd;
            int stall, lat, r;
            bit noise;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            rd = 5'($urandom_range(0, 31));
            stall = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            lat = r == 0 ? -1 : r == 1 ? TO - 1 : r == 2 ? TO : $urandom_range(0, 4);
            noise = 1'($urandom_range(0, 1));
            e = model(we, f3, addr, wdata, rdata, stall, lat);
            txn(we, f3, addr, wdata, rdata, rd, stall, lat, noise, o);
            compare($sformatf("rand%0d", k), e, rd, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
